// File: rtl/cpu_pc_ctrl.sv
// cpu_pc_ctrl: program counter with flag-conditional branches, a return-address
// stack for CALL/RET with sticky overflow/underflow flags, and an absorbing halt state.
module cpu_pc_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RST_ADDR    = 0
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               EN,
  input  logic [2:0]                         OP,
  input  logic [ADDR_W-1:0]                  TARGET,
  input  logic                               C,
  input  logic                               Z,
  input  logic                               B,
  output logic [ADDR_W-1:0]                  PC,
  output logic                               TAKEN,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   SP,
  output logic                               HALTED,
  output logic                               STK_OVF,
  output logic                               STK_UNF
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL = SP_W'(STACK_DEPTH);
  typedef enum logic {RUN, HLT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] stack [2**IDX_W];
  logic [ADDR_W-1:0] pc_inc, pc_n;
  logic [SP_W-1:0] sp_n;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic taken_n, ovf_n, unf_n, push, adv, flag;
  assign adv = EN && state == RUN;
  assign pc_inc = PC + 1'b1;
  assign wr_idx = SP[IDX_W-1:0];
  assign rd_idx = IDX_W'(SP - 1'b1);
  assign HALTED = state == HLT;
  assign flag = OP == 3'b010 ? C : OP == 3'b011 ? Z : B;
  always_comb begin
    pc_n = pc_inc;
    taken_n = 1'b0;
    sp_n = SP;
    state_n = state;
    ovf_n = STK_OVF;
    unf_n = STK_UNF;
    push = 1'b0;
    case (OP)
      3'b001: begin
        pc_n = TARGET;
        taken_n = 1'b1;
      end
      3'b010, 3'b011, 3'b100: begin
        pc_n = flag ? TARGET : pc_inc;
        taken_n = flag;
      end
      3'b101:
        if (SP != FULL) begin
          push = 1'b1;
          sp_n = SP + 1'b1;
          pc_n = TARGET;
          taken_n = 1'b1;
        end else ovf_n = 1'b1;
      3'b110:
        if (SP != '0) begin
          pc_n = stack[rd_idx];
          sp_n = SP - 1'b1;
          taken_n = 1'b1;
        end else unf_n = 1'b1;
      3'b111: begin
        pc_n = PC;
        state_n = HLT;
      end
      default: ;
    endcase
  end
  // stack contents need no reset; only entries below SP are ever read
  always_ff @(posedge CLK)
    if (adv && push) stack[wr_idx] <= pc_inc;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      PC <= ADDR_W'(RST_ADDR);
      SP <= '0;
      TAKEN <= 1'b0;
      state <= RUN;
      STK_OVF <= 1'b0;
      STK_UNF <= 1'b0;
    end else if (adv) begin
      PC <= pc_n;
      SP <= sp_n;
      TAKEN <= taken_n;
      state <= state_n;
      STK_OVF <= ovf_n;
      STK_UNF <= unf_n;
    end else TAKEN <= 1'b0;
endmodule
